// File: rtl/t09_lcd_pkg.sv
// rtl/t09_lcd_pkg.sv - shared types, table lengths and mode encodings for the LCD command sender
package t09_lcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_LOW  = 2'd1,
    WR_HIGH = 2'd2,
    DELAY   = 2'd3
  } state_t;

  // One table entry: delay marker, D/CX level, bus byte (or delay count)
  typedef struct packed {
    logic       is_delay;
    logic       dcx;
    logic [7:0] data;
  } entry_t;

  localparam int INIT_LEN = 8;
  localparam int UPD_LEN  = 4;

  // Controller modes shared with the update controller
  localparam logic [2:0] MODE_IDLE       = 3'd0;
  localparam logic [2:0] MODE_INIT_WAIT  = 3'd1;
  localparam logic [2:0] MODE_UPD_WAIT   = 3'd2;
  localparam logic [2:0] MODE_INIT_WRITE = 3'd3;
  localparam logic [2:0] MODE_UPD_WRITE  = 3'd4;
  localparam logic [2:0] MODE_DONE       = 3'd5;

  // Down-counter load for a delay entry: count*unit cycles, at least one cycle
  function automatic logic [23:0] delay_load(input logic [7:0] count, input logic [23:0] unit);
    logic [23:0] cycles;
    cycles = {16'd0, count} * unit;
    if (cycles == 24'd0) cycles = 24'd1;
    return cycles - 24'd1;
  endfunction

endpackage

// File: rtl/t09_lcd_cmd_rom.sv
// rtl/t09_lcd_cmd_rom.sv - combinational init/update command tables
module t09_lcd_cmd_rom
  import t09_lcd_pkg::*;
(
  input  logic       upd_sel,
  input  logic [2:0] idx,
  output entry_t     entry
);

  // Table lookup: init table when upd_sel=0, update table when upd_sel=1
  always_comb begin
    entry = '0;
    if (!upd_sel) begin
      case (idx)
        3'd0:    entry = {1'b0, 1'b0, 8'h01};  // software reset
        3'd1:    entry = {1'b1, 1'b0, 8'h03};  // wait 3 delay units
        3'd2:    entry = {1'b0, 1'b0, 8'h11};  // sleep out
        3'd3:    entry = {1'b1, 1'b0, 8'h00};  // minimum delay
        3'd4:    entry = {1'b0, 1'b0, 8'h3A};  // pixel format
        3'd5:    entry = {1'b0, 1'b1, 8'h55};  // 16 bpp
        3'd6:    entry = {1'b0, 1'b0, 8'h36};  // memory access control
        default: entry = {1'b0, 1'b0, 8'h29};  // display on
      endcase
    end else begin
      case (idx[1:0])
        2'd0:    entry = {1'b0, 1'b0, 8'h2C};  // memory write
        2'd1:    entry = {1'b0, 1'b1, 8'hA5};
        2'd2:    entry = {1'b0, 1'b1, 8'h5A};
        default: entry = {1'b0, 1'b0, 8'h00};  // nop closes the burst
      endcase
    end
  end

endmodule

// File: rtl/t09_lcd_cmd_sender.sv
// rtl/t09_lcd_cmd_sender.sv - 8080-style LCD command table sender; T09_CMD_DELAY_EN enables timed delay entries
module t09_lcd_cmd_sender
  import t09_lcd_pkg::*;
#(
  parameter int TWRL       = 2,
  parameter int TWRH       = 2,
  parameter int DELAY_UNIT = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       wr,
  input  logic [2:0] mode,
  output logic       pause,
  output logic       cmd_finished,
  output logic       lcd_csx,
  output logic       lcd_dcx,
  output logic       lcd_wrx,
  output logic [7:0] lcd_data
);

  if (TWRL < 1 || TWRL > 15 || TWRH < 1 || TWRH > 15 ||
      DELAY_UNIT < 1 || DELAY_UNIT > 65535) begin : g_param_check
    $error("t09_lcd_cmd_sender: timing parameter out of range");
  end

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  word_cnt_q, word_cnt_d;
  logic        dcx_q, dcx_d;
  logic [7:0]  data_q, data_d;
  entry_t      rom_entry;
  logic        write_mode;
  logic        accept;
`ifdef T09_CMD_DELAY_EN
  logic [23:0] dly_cnt_q, dly_cnt_d;
`endif

  t09_lcd_cmd_rom u_rom (
    .upd_sel (mode == MODE_UPD_WRITE),
    .idx     (idx_q),
    .entry   (rom_entry)
  );

  assign write_mode   = (mode == MODE_INIT_WRITE) || (mode == MODE_UPD_WRITE);
  assign accept       = wr && write_mode && (state_q == IDLE);
  assign cmd_finished = wr & ((mode == MODE_INIT_WRITE) ? (idx_q == 3'(INIT_LEN - 1)) :
                              (mode == MODE_UPD_WRITE)  ? (idx_q == 3'(UPD_LEN - 1))  : 1'b0);

  // Next-state, index, latch and counter logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_cnt_d = word_cnt_q;
    dcx_d      = dcx_q;
    data_d     = data_q;
`ifdef T09_CMD_DELAY_EN
    dly_cnt_d  = dly_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d      = cmd_finished ? 3'd0 : idx_q + 3'd1;
          word_cnt_d = 4'd0;
          if (rom_entry.is_delay) begin
            state_d = DELAY;
`ifdef T09_CMD_DELAY_EN
            dly_cnt_d = delay_load(rom_entry.data, 24'(DELAY_UNIT));
`endif
          end else begin
            state_d = WR_LOW;
            dcx_d   = rom_entry.dcx;
            data_d  = rom_entry.data;
          end
        end else if (mode == MODE_IDLE) begin
          idx_d = 3'd0;
        end
      end
      WR_LOW: begin
        if (word_cnt_q == 4'(TWRL - 1)) begin
          state_d    = WR_HIGH;
          word_cnt_d = 4'd0;
        end else begin
          word_cnt_d = word_cnt_q + 4'd1;
        end
      end
      WR_HIGH: begin
        if (word_cnt_q == 4'(TWRH - 1)) begin
          state_d    = IDLE;
          word_cnt_d = 4'd0;
        end else begin
          word_cnt_d = word_cnt_q + 4'd1;
        end
      end
      DELAY: begin
`ifdef T09_CMD_DELAY_EN
        // Counts down to zero and stops there, so it never wraps
        if (dly_cnt_q == 24'd0) state_d = IDLE;
        else                    dly_cnt_d = dly_cnt_q - 24'd1;
`else
        // Delay entries collapse to a single busy cycle
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index and latched-word registers with asynchronous reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      word_cnt_q <= 4'd0;
      dcx_q      <= 1'b1;
      data_q     <= 8'd0;
`ifdef T09_CMD_DELAY_EN
      dly_cnt_q  <= 24'd0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_cnt_q <= word_cnt_d;
      dcx_q      <= dcx_d;
      data_q     <= data_d;
`ifdef T09_CMD_DELAY_EN
      dly_cnt_q  <= dly_cnt_d;
`endif
    end
  end

  assign pause    = (state_q != IDLE);
  assign lcd_csx  = !((state_q == WR_LOW) || (state_q == WR_HIGH));
  assign lcd_wrx  = (state_q != WR_LOW);
  assign lcd_dcx  = lcd_csx ? 1'b1 : dcx_q;
  assign lcd_data = data_q;

endmodule

// File: doc/t09_lcd_cmd_sender.md
T09_LCD_CMD_SENDER -- requirements
Module: t09_lcd_cmd_sender

Interface
REQ-001 SHALL have parameter TWRL, default 2, meaning WRX-low cycles per bus word (range 1..15).
REQ-002 SHALL have parameter TWRH, default 2, meaning WRX-high cycles per bus word (range 1..15).
REQ-003 SHALL have parameter DELAY_UNIT, default 16, meaning clock cycles per delay-entry count (range 1..65535).
REQ-004 clk  input  1  clock, rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 wr  input  1  one-cycle request from the update controller to issue the next table entry.
REQ-007 mode  input  3  controller state: 0 idle, 1 init-wait, 2 update-wait, 3 init-write, 4 update-write, 5 done.
REQ-008 pause  output  1  sender busy; the controller holds its wait state while high.
REQ-009 cmd_finished  output  1  combinational; high in the wr cycle that issues the last entry of the selected table.
REQ-010 lcd_csx, lcd_dcx, lcd_wrx  output  1 each  8080-style chip select, data/command select (1 = data) and write strobe.
REQ-011 lcd_data  output  8  parallel bus data.

Function
REQ-012 Table entry format SHALL be 10 bits {is_delay, dcx, data[7:0]}; the init table (8 entries) is selected at mode 3 and the update table (4 entries) at mode 4.
REQ-013 States SHALL be IDLE, WR_LOW, WR_HIGH and DELAY.
REQ-014 In IDLE with wr=1 and mode 3 or 4: latch the entry at the current index, increment the index, enter WR_LOW (non-delay entry) or DELAY (delay entry), and register pause=1 for the next cycle.
REQ-015 wr SHALL be ignored when mode is not 3 or 4, or when the state is not IDLE.
REQ-016 WR_LOW SHALL last TWRL cycles with lcd_wrx=0, lcd_csx=0, and lcd_dcx/lcd_data driven from the latched entry; it is followed by WR_HIGH.
REQ-017 WR_HIGH SHALL last TWRH cycles with lcd_wrx=1, lcd_csx=0, and data held; it returns to IDLE with pause=0 in the IDLE cycle.
REQ-018 DELAY SHALL last data*DELAY_UNIT cycles, minimum 1 cycle when data=0, with WRX and CSX high; it then returns to IDLE.
REQ-019 pause SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-020 cmd_finished SHALL equal wr & (mode==3 ? index==7 : mode==4 ? index==3 : 0).
REQ-021 The index SHALL be cleared to 0 on a cmd_finished wr, and on any cycle with mode==0 while the state is IDLE.
REQ-022 The delay counter SHALL be 24 bits wide and SHALL not wrap; the maximum delay is 255*DELAY_UNIT.
REQ-023 In IDLE: lcd_csx=1, lcd_wrx=1, lcd_dcx=1, and lcd_data holds its last value.

Reset
REQ-024 nrst low SHALL force state IDLE, index 0, counters 0, pause=0, lcd_csx=1, lcd_wrx=1, lcd_dcx=1 and lcd_data=0, including mid-word and mid-delay.
REQ-025 The first wr after reset deassertion SHALL be accepted normally.

Configuration
REQ-026 With T09_CMD_DELAY_EN defined, delay entries SHALL behave as in REQ-018.
REQ-027 Without T09_CMD_DELAY_EN, a delay entry SHALL be a NOP: one cycle of pause=1, no bus activity, and index/cmd_finished still advance; the DELAY counter SHALL not be synthesized.

Structure
REQ-028 Package t09_lcd_pkg SHALL hold the state enum, the entry typedef, the table lengths (INIT_LEN=8, UPD_LEN=4) and the mode encodings 0..5 shared with the update controller.
REQ-029 Sub-module t09_lcd_cmd_rom SHALL be purely combinational: inputs table select and index; output the 10-bit entry.

Verification
REQ-030 Reset, then mode=3 and wr pulses driven by a controller model -> 8 entries issued, cmd_finished only on the 8th wr, index back to 0.
REQ-031 Single non-delay entry, TWRL=2, TWRH=2 -> pause high for exactly 4 cycles after wr; lcd_wrx low for 2 cycles; lcd_csx low for 4 cycles.
REQ-032 Delay entry data=3, DELAY_UNIT=16, macro defined -> pause high for 48 cycles with no WRX edge; macro undefined -> pause high for 1 cycle.
REQ-033 wr asserted while busy, or with mode=1 -> ignored; index unchanged and no bus activity.
REQ-034 nrst pulsed during WR_LOW of entry 2 -> all outputs at reset values immediately; the next mode=4 wr issues update entry 0.
REQ-035 Mode returns to 0 after 2 of 8 init entries -> index cleared; the next mode=3 wr issues init entry 0.
